dyn_phase_seq: RTL and testbench
================================

// Module: dyn_phase_seq
// PURPOSE
//  Multi-step phase-shift sequencer driving dyn_phase_stm from the upstream side.
//  - Register interface requests N steps in one direction on one PLL counter.
//  - Block issues one single-cycle DYN_PHASE command per step and waits for the PLL PHASEDONE low/high cycle.
//  - Tracks cumulative signed phase position; reports BUSY/DONE/ERROR back to the register block.
// PARAMETERS
//  STEP_W       8    width of STEPS request (max 255 steps per request)
//  POS_W        10   width of signed POSITION accumulator
//  GAP_CYC      8    idle cycles after PHASEDONE rises before next command (covers stm pipeline, >=6)
//  TIMEOUT_CYC  1024 cycles allowed in any PHASEDONE wait state (only with DYN_PHASE_TIMEOUT_EN)
// PORTS
//  CLK50M      in   1      50 MHz system clock
//  RESET_N     in   1      asynchronous active-low reset
//  START       in   1      1-cycle request pulse; samples STEPS/DIR/CNT_SEL
//  STEPS       in   STEP_W number of steps requested
//  DIR         in   1      1=step up, 0=step down
//  CNT_SEL     in   4      PLL counter select (0 all, 1 M, 2..6 C0..C4)
//  ABORT       in   1      stop at next step boundary
//  POS_CLR     in   1      clear POSITION (ignored while BUSY)
//  PHASEDONE   in   1      from PLL, async: double-flop synchronised internally
//  DYN_PHASE   out  2      to dyn_phase_stm: 00 idle, 01 step up, 10 step down
//  COUNTER     out  4      to dyn_phase_stm: latched CNT_SEL, stable while BUSY
//  BUSY        out  1      request in progress
//  DONE        out  1      1-cycle pulse when request ends (normal, abort or error)
//  ERROR       out  1      sticky; set on timeout, cleared by next accepted START
//  POSITION    out  POS_W  signed count of completed steps (up +1, down -1)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, remaining count 0, sync flops 0.
//  States: IDLE -> ISSUE -> WAIT_LOW -> WAIT_HIGH -> GAP -> (ISSUE | FIN) ; FIN -> IDLE.
//  IDLE: START accepted only here; latch STEPS->rem, DIR, CNT_SEL->COUNTER; clear ERROR; BUSY=1 next cycle.
//   STEPS==0: go to FIN directly, no command issued.
//   START while BUSY: ignored, no side effects.
//  ISSUE: entered only with synced PHASEDONE=1 (else hold); DYN_PHASE = 01/10 for exactly 1 cycle.
//  WAIT_LOW: wait synced PHASEDONE=0 (PLL accepted step).
//  WAIT_HIGH: wait synced PHASEDONE=1; on rise rem-=1, POSITION+=/-1 (same cycle).
//  POSITION saturates at +2^(POS_W-1)-1 / -2^(POS_W-1); never wraps.
//  GAP: count GAP_CYC cycles; then rem==0 or ABORT seen -> FIN, else ISSUE.
//  ABORT: sampled/held as pending from any BUSY state; in-flight step always completes.
//  FIN: DONE=1 one cycle, BUSY=0 same cycle, DYN_PHASE=00, return IDLE.
//  POS_CLR and step completion same cycle cannot occur (POS_CLR ignored while BUSY).
//  Async reset mid-sequence: immediate return to IDLE, DYN_PHASE=00; POSITION cleared.
//  DYN_PHASE is 00 in every state except ISSUE.
// CONFIGURATION
//  DYN_PHASE_TIMEOUT_EN defined:
//   - Watchdog counts in ISSUE/WAIT_LOW/WAIT_HIGH, restarts on every state change.
//   - Reaching TIMEOUT_CYC: ERROR=1, go to FIN (DONE pulses), POSITION unchanged for the failed step.
//  Not defined: no watchdog, waits indefinitely; ERROR tied 0.
// STRUCTURE
//  Shared include dyn_phase_defs.vh:
//   - DYN_PHASE encodings (IDLE 2'b00, UP 2'b01, DOWN 2'b10).
//   - CNT_SEL codes 0..6; sequencer state encodings.
//   - Used by dyn_phase_seq, dyn_phase_stm and the register block.
//  One sub-module dyn_phase_wdog: loadable down-counter + expire flag; instantiated only under DYN_PHASE_TIMEOUT_EN.
// TESTING
//  Bench models PLL: PHASEDONE falls 3 cycles after PHASESTEP rises, rises 10 cycles later.
//  1 START STEPS=3 DIR=1 CNT_SEL=2 -> three 1-cycle DYN_PHASE=01, COUNTER=2 throughout, POSITION=+3, one DONE, ERROR=0.
//  2 START STEPS=0 -> DONE pulse within 2 cycles, no DYN_PHASE activity, POSITION unchanged.
//  3 STEPS=5 DIR=0, ABORT during 2nd WAIT_LOW -> 2nd step completes, DONE, POSITION=-2.
//  4 POSITION=511 (POS_W=10), START STEPS=2 DIR=1 -> POSITION stays 511, DONE normal.
//  5 DYN_PHASE_TIMEOUT_EN, PLL never drops PHASEDONE -> ERROR=1, DONE at TIMEOUT_CYC; next START clears ERROR.
//  6 RESET_N low mid WAIT_HIGH, 2nd START while BUSY -> all outputs 0 immediately; ignored START causes no change.

Source files
------------

// File: rtl/dyn_phase_seq_pkg.sv
// Shared encodings for the dynamic phase-shift path: command codes, PLL counter
// selects, sequencer states and default sizing used by dyn_phase_seq and its watchdog.
package dyn_phase_seq_pkg;

    localparam int STEP_W_DEF      = 8;
    localparam int POS_W_DEF       = 10;
    localparam int GAP_CYC_DEF     = 8;
    localparam int TIMEOUT_CYC_DEF = 1024;

    // Command to dyn_phase_stm; 2'b11 is never driven.
    typedef enum logic [1:0] {
        DP_IDLE = 2'b00,
        DP_UP   = 2'b01,
        DP_DOWN = 2'b10
    } dyn_phase_t;

    typedef enum logic [3:0] {
        CNT_ALL = 4'd0,
        CNT_M   = 4'd1,
        CNT_C0  = 4'd2,
        CNT_C1  = 4'd3,
        CNT_C2  = 4'd4,
        CNT_C3  = 4'd5,
        CNT_C4  = 4'd6
    } cnt_sel_t;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_LOW  = 3'd2,
        S_WAIT_HIGH = 3'd3,
        S_GAP       = 3'd4,
        S_FIN       = 3'd5
    } seq_state_t;

    function automatic dyn_phase_t step_cmd(input logic dir);
        return dir ? DP_UP : DP_DOWN;
    endfunction

endpackage

// File: rtl/dyn_phase_seq_wdog.sv
// Watchdog for the PHASEDONE wait states: loadable down-counter that flags expiry
// once it has spent TIMEOUT_CYC enabled cycles since the last load.
module dyn_phase_wdog
    import dyn_phase_seq_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic CLK50M,
    input  logic RESET_N,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge CLK50M or negedge RESET_N) begin
        if (!RESET_N) begin
            count_q <= LOAD_VAL;
        end else if (load) begin
            count_q <= LOAD_VAL;
        end else if (en && count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign expired = en && (count_q == '0);

endmodule

// File: rtl/dyn_phase_seq.sv
// Multi-step PLL phase-shift sequencer: issues one DYN_PHASE command per step,
// paces on PHASEDONE and tracks a saturating signed position.
// Optional watchdog on the PHASEDONE waits: define DYN_PHASE_TIMEOUT_EN.
module dyn_phase_seq
    import dyn_phase_seq_pkg::*;
#(
    parameter int STEP_W      = STEP_W_DEF,
    parameter int POS_W       = POS_W_DEF,
    parameter int GAP_CYC     = GAP_CYC_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              CLK50M,
    input  logic              RESET_N,
    input  logic              START,
    input  logic [STEP_W-1:0] STEPS,
    input  logic              DIR,
    input  logic [3:0]        CNT_SEL,
    input  logic              ABORT,
    input  logic              POS_CLR,
    input  logic              PHASEDONE,
    output logic [1:0]        DYN_PHASE,
    output logic [3:0]        COUNTER,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERROR,
    output logic [POS_W-1:0]  POSITION
);

    localparam int GAP_W = $clog2(GAP_CYC + 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYC - 1);
    localparam logic signed [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
    localparam logic signed [POS_W-1:0] POS_MIN = {1'b1, {(POS_W-1){1'b0}}};

    seq_state_t               state_q, state_d;
    logic                     pd_meta, pd_sync;
    logic [STEP_W-1:0]        rem_q;
    logic                     dir_q;
    logic [3:0]               counter_q;
    logic                     abort_pend_q;
    logic [GAP_W-1:0]         gap_q;
    logic signed [POS_W-1:0]  pos_q;
    logic                     busy;
    logic                     start_acc;
    logic                     step_done;
    logic                     timeout_hit;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge CLK50M or negedge RESET_N) begin
        if (!RESET_N) begin
            pd_meta <= 1'b0;
            pd_sync <= 1'b0;
        end else begin
            pd_meta <= PHASEDONE;
            pd_sync <= pd_meta;
        end
    end

    always_ff @(posedge CLK50M or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        step_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    start_acc = 1'b1;
                    state_d   = (STEPS == '0) ? S_FIN : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (timeout_hit)  state_d = S_FIN;
                else if (pd_sync) state_d = S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
                if (timeout_hit)   state_d = S_FIN;
                else if (!pd_sync) state_d = S_WAIT_HIGH;
            end
            S_WAIT_HIGH: begin
                if (timeout_hit) begin
                    state_d = S_FIN;
                end else if (pd_sync) begin
                    step_done = 1'b1;
                    state_d   = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = (rem_q == '0 || abort_pend_q) ? S_FIN : S_ISSUE;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q inside {S_ISSUE, S_WAIT_LOW, S_WAIT_HIGH, S_GAP});

    always_ff @(posedge CLK50M or negedge RESET_N) begin
        if (!RESET_N) begin
            rem_q        <= '0;
            dir_q        <= 1'b0;
            counter_q    <= '0;
            abort_pend_q <= 1'b0;
            gap_q        <= '0;
        end else begin
            if (start_acc) begin
                rem_q     <= STEPS;
                dir_q     <= DIR;
                counter_q <= CNT_SEL;
            end else if (step_done) begin
                rem_q <= rem_q - 1'b1;
            end

            // Abort only takes effect at the GAP decision, so the in-flight step finishes.
            if (start_acc) begin
                abort_pend_q <= 1'b0;
            end else if (busy && ABORT) begin
                abort_pend_q <= 1'b1;
            end

            if (step_done) begin
                gap_q <= GAP_LOAD;
            end else if (state_q == S_GAP && gap_q != '0) begin
                gap_q <= gap_q - 1'b1;
            end
        end
    end

    always_ff @(posedge CLK50M or negedge RESET_N) begin
        if (!RESET_N) begin
            pos_q <= '0;
        end else if (POS_CLR && !busy) begin
            pos_q <= '0;
        end else if (step_done) begin
            if (dir_q) begin
                if (pos_q != POS_MAX) pos_q <= pos_q + POS_W'(1);
            end else begin
                if (pos_q != POS_MIN) pos_q <= pos_q - POS_W'(1);
            end
        end
    end

`ifdef DYN_PHASE_TIMEOUT_EN
    logic wdog_en;
    logic wdog_load;
    logic error_q;

    // Restart on every state change so each wait gets the full budget.
    assign wdog_en   = (state_q inside {S_ISSUE, S_WAIT_LOW, S_WAIT_HIGH});
    assign wdog_load = (state_d != state_q);

    dyn_phase_wdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wdog (
        .CLK50M  (CLK50M),
        .RESET_N (RESET_N),
        .load    (wdog_load),
        .en      (wdog_en),
        .expired (timeout_hit)
    );

    always_ff @(posedge CLK50M or negedge RESET_N) begin
        if (!RESET_N) begin
            error_q <= 1'b0;
        end else if (start_acc) begin
            error_q <= 1'b0;
        end else if (timeout_hit) begin
            error_q <= 1'b1;
        end
    end

    assign ERROR = error_q;
`else
    assign timeout_hit = 1'b0;
    assign ERROR       = 1'b0;
`endif

    // A command is only driven once the PLL reports ready, and for one cycle only.
    assign DYN_PHASE = (state_q == S_ISSUE && pd_sync && !timeout_hit) ? step_cmd(dir_q) : DP_IDLE;
    assign COUNTER   = counter_q;
    assign BUSY      = busy;
    assign DONE      = (state_q == S_FIN);
    assign POSITION  = pos_q;

endmodule

// File: tb/tb_dyn_phase_seq.sv
// Self-checking bench for dyn_phase_seq: PLL PHASEDONE model, table-driven requests,
// hand-written abort/saturation/reset/timeout sequences and randomized requests.
module tb_dyn_phase_seq;

    localparam int POS_MAX     = 511;
    localparam int POS_MIN     = -512;
    localparam int TIMEOUT_CYC = 1024;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] steps_in;
    logic       dir_in;
    logic [3:0] cnt_sel;
    logic       abort_in;
    logic       pos_clr;
    logic       phasedone;
    logic [1:0] dyn_phase;
    logic [3:0] counter;
    logic       busy;
    logic       done;
    logic       error;
    logic [9:0] position;

    int checks = 0;
    int errors = 0;
    int model_pos = 0;
    bit pll_stuck = 1'b0;

    dyn_phase_seq dut (
        .CLK50M    (clk),
        .RESET_N   (rst_n),
        .START     (start),
        .STEPS     (steps_in),
        .DIR       (dir_in),
        .CNT_SEL   (cnt_sel),
        .ABORT     (abort_in),
        .POS_CLR   (pos_clr),
        .PHASEDONE (phasedone),
        .DYN_PHASE (dyn_phase),
        .COUNTER   (counter),
        .BUSY      (busy),
        .DONE      (done),
        .ERROR     (error),
        .POSITION  (position)
    );

    always #10 clk = ~clk;

    // PLL: PHASEDONE falls 3 cycles after a step command, rises 10 cycles later.
    initial begin
        phasedone = 1'b1;
        forever begin
            @(negedge clk);
            if (dyn_phase != 2'b00 && !pll_stuck) begin
                repeat (3) @(negedge clk);
                phasedone = 1'b0;
                repeat (10) @(negedge clk);
                phasedone = 1'b1;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int pos_now();
        return int'($signed(position));
    endfunction

    // Reference: each completed step moves the position by one, clamped to the signed range.
    function automatic int model_apply(input int p, input int n, input bit up);
        for (int i = 0; i < n; i++) begin
            if (up) p = (p < POS_MAX) ? p + 1 : p;
            else    p = (p > POS_MIN) ? p - 1 : p;
        end
        return p;
    endfunction

    task automatic run_req(input string tag, input int steps, input bit dir, input logic [3:0] sel,
                           input int abort_at, input int noise_at, input int exp_pulses, output int cyc);
        int ups, dns, dones, width_bad, sel_bad, busy_bad, budget;
        logic [1:0] prev;
        bit abort_done, noise_done, noise_on;
        ups = 0; dns = 0; dones = 0; width_bad = 0; sel_bad = 0; busy_bad = 0;
        abort_done = 0; noise_done = 0; noise_on = 0;
        budget = 40 * (steps + 2) + 100;
        @(negedge clk);
        start = 1'b1; steps_in = 8'(steps); dir_in = dir; cnt_sel = sel;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        prev = 2'b00;
        while (cyc < budget && dones == 0) begin
            if (dyn_phase == 2'b01)      ups++;
            else if (dyn_phase == 2'b10) dns++;
            else if (dyn_phase == 2'b11) width_bad++;
            if (dyn_phase != 2'b00 && prev != 2'b00) width_bad++;
            prev = dyn_phase;
            if (busy && counter != sel) sel_bad++;
            if (done) begin
                dones++;
                if (busy) busy_bad++;
            end
            abort_in = 1'b0;
            if (noise_on) begin
                start = 1'b0; pos_clr = 1'b0; steps_in = 8'(steps); dir_in = dir; cnt_sel = sel;
                noise_on = 0;
            end
            if (abort_at > 0 && !abort_done && ups + dns == abort_at && dyn_phase == 2'b00) begin
                abort_in = 1'b1;
                abort_done = 1;
            end
            if (noise_at > 0 && !noise_done && ups + dns == noise_at && dyn_phase == 2'b00) begin
                start = 1'b1; steps_in = 8'd7; dir_in = ~dir; cnt_sel = sel ^ 4'h1; pos_clr = 1'b1;
                noise_done = 1; noise_on = 1;
            end
            if (dones == 0) begin
                @(negedge clk);
                cyc++;
            end
        end
        abort_in = 1'b0; start = 1'b0; pos_clr = 1'b0;
        check({tag, ".done"}, dones, 1);
        check({tag, ".ups"}, ups, dir ? exp_pulses : 0);
        check({tag, ".downs"}, dns, dir ? 0 : exp_pulses);
        check({tag, ".cmd_width"}, width_bad, 0);
        check({tag, ".counter_stable"}, sel_bad, 0);
        check({tag, ".busy_at_done"}, busy_bad, 0);
        @(negedge clk);
        check({tag, ".done_single"}, int'(done), 0);
        check({tag, ".idle_after"}, int'(busy), 0);
    endtask

    task automatic clear_pos();
        @(negedge clk);
        pos_clr = 1'b1;
        @(negedge clk);
        pos_clr = 1'b0;
        model_pos = 0;
        check("pos_clr", pos_now(), 0);
    endtask

    typedef struct {
        int         steps;
        bit         dir;
        logic [3:0] sel;
        int         exp_pos;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int cyc, n, k, exp_n, waited, dones_seen;
        bit d;
        logic [3:0] s;

        vecs[0] = '{steps: 3, dir: 1'b1, sel: 4'd2, exp_pos: 3};
        vecs[1] = '{steps: 0, dir: 1'b1, sel: 4'd5, exp_pos: 3};
        vecs[2] = '{steps: 4, dir: 1'b0, sel: 4'd1, exp_pos: -1};
        vecs[3] = '{steps: 1, dir: 1'b1, sel: 4'd6, exp_pos: 0};

        rst_n = 1'b0; start = 1'b0; steps_in = '0; dir_in = 1'b0; cnt_sel = '0;
        abort_in = 1'b0; pos_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.dyn_phase", int'(dyn_phase), 0);
        check("rst.counter", int'(counter), 0);
        check("rst.busy", int'(busy), 0);
        check("rst.done", int'(done), 0);
        check("rst.error", int'(error), 0);
        check("rst.position", pos_now(), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            run_req($sformatf("vec%0d", i), vecs[i].steps, vecs[i].dir, vecs[i].sel, 0, 0, vecs[i].steps, cyc);
            check($sformatf("vec%0d.position", i), pos_now(), vecs[i].exp_pos);
            check($sformatf("vec%0d.error", i), int'(error), 0);
            if (vecs[i].steps == 0) check("zero_steps.latency_ok", int'(cyc <= 2), 1);
        end
        model_pos = 0;

        // Abort while the second step is waiting for PHASEDONE low.
        run_req("abort", 5, 1'b0, 4'd3, 2, 0, 2, cyc);
        model_pos = model_apply(model_pos, 2, 1'b0);
        check("abort.position", pos_now(), -2);

        // START and POS_CLR while busy must be ignored.
        run_req("noise", 3, 1'b1, 4'd4, 0, 1, 3, cyc);
        model_pos = model_apply(model_pos, 3, 1'b1);
        check("noise.position", pos_now(), model_pos);

        for (int i = 0; i < 8; i++) begin
            n = $urandom_range(1, 12);
            d = 1'($urandom_range(0, 1));
            s = 4'($urandom_range(0, 6));
            k = ($urandom_range(0, 2) == 0) ? $urandom_range(1, n) : 0;
            exp_n = (k > 0 && k < n) ? k : n;
            run_req($sformatf("rnd%0d", i), n, d, s, k, 0, exp_n, cyc);
            model_pos = model_apply(model_pos, exp_n, d);
            check($sformatf("rnd%0d.position", i), pos_now(), model_pos);
        end

        // Positive and negative saturation.
        clear_pos();
        run_req("sat_up_a", 255, 1'b1, 4'd0, 0, 0, 255, cyc);
        run_req("sat_up_b", 255, 1'b1, 4'd0, 0, 0, 255, cyc);
        run_req("sat_up_c", 1, 1'b1, 4'd0, 0, 0, 1, cyc);
        model_pos = model_apply(model_pos, 511, 1'b1);
        check("sat_up.reach", pos_now(), 511);
        run_req("sat_up_hold", 2, 1'b1, 4'd0, 0, 0, 2, cyc);
        model_pos = model_apply(model_pos, 2, 1'b1);
        check("sat_up.hold", pos_now(), model_pos);
        clear_pos();
        run_req("sat_dn_a", 255, 1'b0, 4'd1, 0, 0, 255, cyc);
        run_req("sat_dn_b", 255, 1'b0, 4'd1, 0, 0, 255, cyc);
        run_req("sat_dn_c", 2, 1'b0, 4'd1, 0, 0, 2, cyc);
        run_req("sat_dn_hold", 2, 1'b0, 4'd1, 0, 0, 2, cyc);
        model_pos = model_apply(model_pos, 514, 1'b0);
        check("sat_dn.hold", pos_now(), model_pos);

        // PLL never drops PHASEDONE.
        clear_pos();
        pll_stuck = 1'b1;
        @(negedge clk);
        start = 1'b1; steps_in = 8'd2; dir_in = 1'b1; cnt_sel = 4'd2;
        @(negedge clk);
        start = 1'b0;
        waited = 0;
        while (waited < 20 && dyn_phase == 2'b00) begin
            @(negedge clk);
            waited++;
        end
        check("stuck.cmd_issued", int'(dyn_phase), 1);
        waited = 0;
        dones_seen = 0;
`ifdef DYN_PHASE_TIMEOUT_EN
        while (waited < TIMEOUT_CYC + 100 && dones_seen == 0) begin
            @(negedge clk);
            waited++;
            if (done) dones_seen++;
        end
        check("timeout.done", dones_seen, 1);
        check("timeout.latency_ok", int'(waited >= TIMEOUT_CYC - 2 && waited <= TIMEOUT_CYC + 2), 1);
        check("timeout.error", int'(error), 1);
        check("timeout.position", pos_now(), 0);
        pll_stuck = 1'b0;
        repeat (3) @(negedge clk);
        check("timeout.error_sticky", int'(error), 1);
        run_req("after_timeout", 1, 1'b1, 4'd3, 0, 0, 1, cyc);
        model_pos = model_apply(model_pos, 1, 1'b1);
        check("after_timeout.error_cleared", int'(error), 0);
        check("after_timeout.position", pos_now(), model_pos);
`else
        while (waited < 200) begin
            @(negedge clk);
            waited++;
            if (done) dones_seen++;
        end
        check("stuck.no_done", dones_seen, 0);
        check("stuck.busy", int'(busy), 1);
        check("stuck.error", int'(error), 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        pll_stuck = 1'b0;
        repeat (3) @(negedge clk);
        check("stuck.reset_idle", int'(busy), 0);
`endif

        // Reset in the middle of WAIT_HIGH.
        run_req("pre_reset", 2, 1'b1, 4'd5, 0, 0, 2, cyc);
        @(negedge clk);
        start = 1'b1; steps_in = 8'd3; dir_in = 1'b1; cnt_sel = 4'd5;
        @(negedge clk);
        start = 1'b0;
        waited = 0;
        while (waited < 40 && dyn_phase == 2'b00) begin
            @(negedge clk);
            waited++;
        end
        check("mid_reset.cmd_issued", int'(dyn_phase), 1);
        repeat (9) @(negedge clk);
        check("mid_reset.busy_before", int'(busy), 1);
        check("mid_reset.pos_before", int'(pos_now() != 0), 1);
        #3 rst_n = 1'b0;
        #1;
        check("mid_reset.dyn_phase", int'(dyn_phase), 0);
        check("mid_reset.counter", int'(counter), 0);
        check("mid_reset.busy", int'(busy), 0);
        check("mid_reset.done", int'(done), 0);
        check("mid_reset.error", int'(error), 0);
        check("mid_reset.position", pos_now(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_pos = 0;
        repeat (20) @(negedge clk);
        run_req("post_reset", 2, 1'b0, 4'd6, 0, 0, 2, cyc);
        model_pos = model_apply(model_pos, 2, 1'b0);
        check("post_reset.position", pos_now(), model_pos);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
